// File: rtl/nap_timer_ctrl_if.sv
// Control/status bundle between the nap timer controller and its neighbours.
// The i_snooze member exists only when SNOOZE_EN is defined.
interface nap_timer_ctrl_if;
   logic        i_tick;
   logic [23:0] i_set_time;
   logic        i_start;
   logic        i_pause;
   logic        i_cancel;
   logic        i_alarm_ack;
`ifdef SNOOZE_EN
   logic        i_snooze;
`endif
   logic [23:0] o_remain;
   logic        o_running;
   logic        o_paused;
   logic        o_alarm;
   logic        o_done;
   logic        o_load_err;

   modport slave (
      input  i_tick, i_set_time, i_start, i_pause, i_cancel, i_alarm_ack,
`ifdef SNOOZE_EN
      input  i_snooze,
`endif
      output o_remain, o_running, o_paused, o_alarm, o_done, o_load_err
   );

   modport master (
      output i_tick, i_set_time, i_start, i_pause, i_cancel, i_alarm_ack,
`ifdef SNOOZE_EN
      output i_snooze,
`endif
      input  o_remain, o_running, o_paused, o_alarm, o_done, o_load_err
   );
endinterface

// File: rtl/nap_timer_ctrl.sv
// Nap timer countdown: loads a BCD hh:mm:ss duration, counts down on 1 Hz ticks, raises alarm at zero.
// Define SNOOZE_EN to add the snooze input that reloads SNOOZE_MIN minutes from ALARM.
module nap_timer_ctrl #(
   parameter int ALARM_TICKS = 30,
   parameter int SNOOZE_MIN  = 5
) (
   input  logic            clk,
   input  logic            rst,
   nap_timer_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

   localparam logic [7:0] LP_LAST_TICK = 8'(ALARM_TICKS - 1);
`ifdef SNOOZE_EN
   localparam logic [7:0] LP_SNOOZE_BCD = {4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10)};
`endif

   state_t      r_state;
   logic [23:0] r_remain;
   logic [7:0]  r_alarmCnt;
   logic        r_tickQ;
   logic        r_done;
   logic        r_loadErr;

   logic        w_tickEdge;
   logic        w_startOk;
   logic [23:0] w_remainDec;

   // Hour field compares as hex once every digit is known to be decimal.
   function automatic logic timeValid(input logic [23:0] t);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (t[4*k +: 4] > 4'd9) ok = 1'b0;
      end
      if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
      if (t[23:16] > 8'h23) ok = 1'b0;
      if (t == 24'h000000) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [23:0] bcdDec(input logic [23:0] t);
      logic [23:0] r;
      logic        borrow;
      r      = t;
      borrow = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (borrow) begin
            if (r[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = (k == 1 || k == 3) ? 4'd5 : 4'd9;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign w_tickEdge  = bus.i_tick & ~r_tickQ;
   assign w_startOk   = timeValid(bus.i_set_time);
   assign w_remainDec = bcdDec(r_remain);

   // Request priority: cancel, start, snooze, alarm_ack, pause, tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_remain   <= 24'h000000;
         r_alarmCnt <= 8'd0;
         r_tickQ    <= 1'b0;
         r_done     <= 1'b0;
         r_loadErr  <= 1'b0;
      end else begin
         r_tickQ   <= bus.i_tick;
         r_done    <= 1'b0;
         r_loadErr <= 1'b0;
         if (bus.i_cancel) begin
            r_state    <= ST_IDLE;
            r_remain   <= 24'h000000;
            r_alarmCnt <= 8'd0;
         end else if (bus.i_start && r_state != ST_ALARM) begin
            if (w_startOk) begin
               r_remain <= bus.i_set_time;
               r_state  <= ST_RUN;
            end else begin
               r_loadErr <= 1'b1;
            end
         end
`ifdef SNOOZE_EN
         else if (bus.i_snooze && r_state == ST_ALARM) begin
            r_remain   <= {8'h00, LP_SNOOZE_BCD, 8'h00};
            r_alarmCnt <= 8'd0;
            r_state    <= ST_RUN;
         end
`endif
         else begin
            case (r_state)
               ST_RUN: begin
                  if (bus.i_pause) begin
                     r_state <= ST_PAUSE;
                  end else if (w_tickEdge && r_remain != 24'h000000) begin
                     r_remain <= w_remainDec;
                     if (w_remainDec == 24'h000000) begin
                        r_state    <= ST_ALARM;
                        r_done     <= 1'b1;
                        r_alarmCnt <= 8'd0;
                     end
                  end
               end
               ST_PAUSE: begin
                  if (bus.i_pause) r_state <= ST_RUN;
               end
               ST_ALARM: begin
                  if (bus.i_alarm_ack) begin
                     r_state    <= ST_IDLE;
                     r_alarmCnt <= 8'd0;
                  end else if (w_tickEdge) begin
                     if (ALARM_TICKS != 0 && r_alarmCnt == LP_LAST_TICK) begin
                        r_state    <= ST_IDLE;
                        r_alarmCnt <= 8'd0;
                     end else if (r_alarmCnt != 8'hFF) begin
                        r_alarmCnt <= r_alarmCnt + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_remain   = r_remain;
   assign bus.o_running  = (r_state == ST_RUN);
   assign bus.o_paused   = (r_state == ST_PAUSE);
   assign bus.o_alarm    = (r_state == ST_ALARM);
   assign bus.o_done     = r_done;
   assign bus.o_load_err = r_loadErr;
endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Directed bench for nap_timer_ctrl: two instances (ALARM_TICKS = 3 and 0) share one stimulus stream.
// Expected words are {remain, running, paused, alarm, done, load_err}.
module tb_nap_timer_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   nap_timer_ctrl_if bus3 ();
   nap_timer_ctrl_if bus0 ();

   nap_timer_ctrl #(.ALARM_TICKS(3), .SNOOZE_MIN(5)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
   nap_timer_ctrl #(.ALARM_TICKS(0), .SNOOZE_MIN(5)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   assign bus0.i_tick      = bus3.i_tick;
   assign bus0.i_set_time  = bus3.i_set_time;
   assign bus0.i_start     = bus3.i_start;
   assign bus0.i_pause     = bus3.i_pause;
   assign bus0.i_cancel    = bus3.i_cancel;
   assign bus0.i_alarm_ack = bus3.i_alarm_ack;
`ifdef SNOOZE_EN
   assign bus0.i_snooze    = bus3.i_snooze;
`endif

   typedef struct {
      logic        cancel;
      logic        start;
      logic        pause;
      logic        ack;
      logic        tick;
      logic [23:0] setTime;
      logic [28:0] exp;
   } vec_t;

   vec_t vecs[20];

   function automatic logic [28:0] pack3();
      return {bus3.o_remain, bus3.o_running, bus3.o_paused, bus3.o_alarm, bus3.o_done, bus3.o_load_err};
   endfunction

   function automatic logic [28:0] pack0();
      return {bus0.o_remain, bus0.o_running, bus0.o_paused, bus0.o_alarm, bus0.o_done, bus0.o_load_err};
   endfunction

   function automatic logic [23:0] toBcd(input int secs);
      int h, m, s;
      h = secs / 3600;
      m = (secs % 3600) / 60;
      s = secs % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic checkOutput(input string name, input logic [28:0] exp, input logic [28:0] act);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic cancel, input logic start, input logic pause,
                                input logic ack, input logic tick, input logic [23:0] setTime);
      bus3.i_cancel    = cancel;
      bus3.i_start     = start;
      bus3.i_pause     = pause;
      bus3.i_alarm_ack = ack;
      bus3.i_tick      = tick;
      bus3.i_set_time  = setTime;
      @(posedge clk);
      #1;
      bus3.i_cancel    = 1'b0;
      bus3.i_start     = 1'b0;
      bus3.i_pause     = 1'b0;
      bus3.i_alarm_ack = 1'b0;
      bus3.i_tick      = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic tickAndCheck(input string name, input logic [28:0] exp);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      checkOutput(name, exp, pack3());
      idle();
   endtask

   initial begin
      bus3.i_cancel    = 1'b0;
      bus3.i_start     = 1'b0;
      bus3.i_pause     = 1'b0;
      bus3.i_alarm_ack = 1'b0;
      bus3.i_tick      = 1'b0;
      bus3.i_set_time  = 24'h0;
`ifdef SNOOZE_EN
      bus3.i_snooze    = 1'b0;
`endif

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000060, {24'h000000, 5'b00001}};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h240000, {24'h000000, 5'b00001}};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, {24'h000000, 5'b00001}};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00000A, {24'h000000, 5'b00001}};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h235959, {24'h235959, 5'b10000}};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h010000, {24'h010000, 5'b10000}};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h005959, 5'b10000}};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, {24'h005959, 5'b01000}};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h005959, 5'b01000}};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h005959, 5'b01000}};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, {24'h005959, 5'b10000}};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h005958, 5'b10000}};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000002, {24'h000002, 5'b10000}};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h000001, 5'b10000}};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h000000, 5'b00110}};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, {24'h000000, 5'b00100}};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000010, {24'h000000, 5'b00100}};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h000000, 5'b00100}};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h000000, 5'b00100}};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, {24'h000000, 5'b00000}};

      #2 rst = 1'b1;
      #1;
      checkOutput("reset3", 29'h0, pack3());
      checkOutput("reset0", 29'h0, pack0());
      idle();
      idle();
      rst = 1'b0;
      idle();

      // Both instances match until the third alarm tick, where only ALARM_TICKS = 3 clears.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].cancel, vecs[i].start, vecs[i].pause, vecs[i].ack, vecs[i].tick, vecs[i].setTime);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp, pack3());
         if (i < 19) checkOutput($sformatf("vec%0d_t0", i), vecs[i].exp, pack0());
         idle();
      end

      for (int n = 0; n < 100; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
         checkOutput($sformatf("hold_t0_%0d", n), {24'h0, 5'b00100}, pack0());
         idle();
      end
      checkOutput("idle_t3", 29'h0, pack3());
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
      checkOutput("ack_t0", 29'h0, pack0());
      idle();

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000102);
      checkOutput("load102", {24'h000102, 5'b10000}, pack3());
      idle();
      for (int n = 1; n <= 62; n++) begin
         tickAndCheck($sformatf("count%0d", n),
                      (n < 62) ? {toBcd(62 - n), 5'b10000} : {24'h000000, 5'b00110});
      end
      checkOutput("doneOnce", {24'h0, 5'b00100}, pack3());
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      checkOutput("cancelAlarm", 29'h0, pack3());
      checkOutput("cancelAlarm_t0", 29'h0, pack0());
      idle();

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000042);
      idle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      checkOutput("pauseIn", {24'h000042, 5'b01000}, pack3());
      idle();
      for (int n = 0; n < 5; n++) begin
         tickAndCheck($sformatf("frozen%0d", n), {24'h000042, 5'b01000});
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      checkOutput("resume", {24'h000042, 5'b10000}, pack3());
      idle();
      tickAndCheck("afterResume", {24'h000041, 5'b10000});
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      checkOutput("pauseCancel", 29'h0, pack3());
      idle();

      // A tick held high for several clocks counts once.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000010);
      idle();
      bus3.i_tick = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus3.i_tick = 1'b0;
      checkOutput("heldTick", {24'h000009, 5'b10000}, pack3());
      idle();

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000042);
      checkOutput("reload42", {24'h000042, 5'b10000}, pack3());
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncReset3", 29'h0, pack3());
      checkOutput("asyncReset0", 29'h0, pack0());
      #1 rst = 1'b0;
      idle();

`ifdef SNOOZE_EN
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001);
      idle();
      tickAndCheck("snoozeArm", {24'h000000, 5'b00110});
      bus3.i_snooze = 1'b1;
      @(posedge clk);
      #1;
      bus3.i_snooze = 1'b0;
      checkOutput("snoozeLoad", {24'h000500, 5'b10000}, pack3());
      idle();
      for (int n = 1; n <= 300; n++) begin
         tickAndCheck($sformatf("snooze%0d", n),
                      (n < 300) ? {toBcd(300 - n), 5'b10000} : {24'h000000, 5'b00110});
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
      idle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/nap_timer_ctrl.md
Name: nap_timer_ctrl

Overview:
Countdown controller for the nap timer: loads a 24-bit BCD hh:mm:ss duration, decrements it once per 1 Hz tick and raises the wake alarm on reaching 00:00:00. Its zero test matches the time_check OR-reduction: a value is "expired" when all 24 bits are 0. Sits between the user-input decoder and the display/buzzer drivers.

Parameters:
ALARM_TICKS, 30, ticks the alarm stays asserted before auto-clear; 0 = until acknowledged or cancelled.
SNOOZE_MIN, 5, snooze reload in minutes, 1..59 (used only when SNOOZE_EN is defined).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-clk pulse per second; ignored when held longer (edge-sensitive to the clk sample only)
set_time  in  24  BCD duration {hh[23:16], mm[15:8], ss[7:0]}
start  in  1  load set_time and run (pulse)
pause  in  1  toggle RUN/PAUSE (pulse)
cancel  in  1  abort to IDLE (pulse)
alarm_ack  in  1  silence alarm (pulse)
remain  out  24  current remaining BCD time
running  out  1  state == RUN
paused  out  1  state == PAUSE
alarm  out  1  state == ALARM
done  out  1  one-clk pulse on the edge that enters ALARM
load_err  out  1  one-clk pulse when start is rejected

Behaviour:
- Reset (async, any time, including mid-count or mid-alarm): state IDLE, remain = 0, alarm_cnt = 0, all outputs 0.
- States: IDLE, RUN, PAUSE, ALARM. All transitions are registered on the clk rising edge.
- Input priority in the same cycle: cancel > start > alarm_ack > pause > tick.
- cancel: from any state -> IDLE. remain is cleared to 0 and alarm drops on the next edge.
- start: accepted in IDLE, RUN or PAUSE, not in ALARM (ignored there). It is valid only when:
  - every digit is <= 9;
  - ss tens <= 5 and mm tens <= 5;
  - hh <= 23;
  - set_time != 0.
  When valid: remain <= set_time, state -> RUN. When invalid: state and remain are unchanged and load_err pulses for 1 cycle.
- pause: RUN -> PAUSE, PAUSE -> RUN. Ignored in IDLE and ALARM.
- RUN with tick: remain <= BCD decrement by 1 s.
  - Borrow chain: ss 00 -> 59 borrows from mm; mm 00 -> 59 borrows from hh.
  - Per-digit rule: ones 0 -> 9 with borrow; tens decrement on ones borrow.
  - remain is never decremented when it is 0.
- Expiry: if the decremented value is 0, on that same edge state -> ALARM, done = 1 for exactly that cycle, alarm_cnt <= 0. Latency: remain = 000001 plus 1 tick gives alarm high on the following clk.
- PAUSE: tick is ignored and remain is frozen.
- ALARM:
  - tick increments alarm_cnt.
  - If ALARM_TICKS != 0 and alarm_cnt reaches ALARM_TICKS-1 with a tick -> IDLE.
  - alarm_ack -> IDLE.
  - remain stays 0.
- IDLE: remain holds its last value (0 after expiry or cancel).
- alarm_cnt is 8 bits and saturates; it is unused when ALARM_TICKS = 0.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.

Optional Feature:
SNOOZE_EN
- Defined: adds input port snooze (1 bit, pulse). In ALARM, with priority below cancel and above alarm_ack: remain <= {8'h00, BCD(SNOOZE_MIN), 8'h00}, alarm_cnt <= 0, state -> RUN, no done pulse. snooze in other states is ignored.
- Undefined: the port does not exist and the behaviour is exactly as above.

Test Plan:
- Reset mid-RUN with remain = 00:00:42 -> all outputs 0 and remain = 0 immediately, without waiting for clk.
- start with set_time = 24'h000102, then 62 ticks -> remain steps 000101 ... 000100, 000059 ... 000001. The 62nd tick gives remain 000000, alarm = 1 and a single done pulse.
- set_time = 24'h010000, 1 tick -> remain = 24'h005959. set_time = 24'h000060, 24'h240000 or 0 -> load_err pulses and state stays IDLE.
- RUN, pause, 5 ticks, pause, 1 tick -> remain frozen during PAUSE, then decrements by exactly 1. pause and cancel in the same cycle -> IDLE.
- ALARM with ALARM_TICKS = 3 -> alarm clears after the 3rd tick. With ALARM_TICKS = 0 -> alarm holds through 100 ticks until alarm_ack. start during ALARM is ignored.
- SNOOZE_EN defined, SNOOZE_MIN = 5: snooze in ALARM -> remain = 24'h000500, running = 1; 300 ticks later done pulses again.
